pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
// PURPOSE
//  Drives the RESET input of the rPLL clock generator and watches its LOCK output.
//  Holds the downstream I2C/PWM logic in reset until the PLL is locked and stable.
//  Retries the PLL on lock timeout or loss of lock, and flags a hard failure.
//  Runs on the 27 MHz board reference clock, i.e. the same clock that feeds the PLL.
// PARAMETERS
//  RST_CYCLES     16     cycles pll_reset is held high per attempt (>=1)
//  LOCK_TIMEOUT   27000  cycles to wait for synced lock before retry (1 ms @27 MHz)
//  STABLE_CYCLES  270    consecutive locked cycles required before sys_rst_n release
//  MAX_RETRY      4      timeouts/losses tolerated; the next one enters FAIL
//  GLITCH_CYCLES  4      lock-low cycles treated as real loss (macro build only)
// PORTS
//  clkin       in   1  27 MHz reference clock
//  rst_n       in   1  synchronous active-low reset
//  pll_lock    in   1  PLL LOCK, asynchronous to clkin
//  relock_req  in   1  single-cycle pulse: force a new PLL reset sequence
//  pll_reset   out  1  to PLL RESET, active-high
//  sys_rst_n   out  1  active-low reset for PLL-clocked logic (synchronise per domain)
//  locked      out  1  high only in RUN
//  lock_lost   out  1  one-cycle pulse on RUN->RESET_PLL caused by lock loss
//  fail        out  1  sticky: retries exhausted
//  retry_cnt   out  $clog2(MAX_RETRY+1)  attempts consumed since rst_n
// BEHAVIOUR
//  - One clock (clkin); reset is synchronous and active-low (rst_n). Sampled only on posedge clkin.
//  - Reset values: pll_reset=1, sys_rst_n=0, locked=0, lock_lost=0, fail=0, retry_cnt=0,
//    state=RESET_PLL, counter=0.
//  - Synchroniser: pll_lock passes through a 2-flop sync to give lock_s.
//    A lock edge reaches lock_s 2 cycles later.
//  - FSM (all outputs registered):
//    RESET_PLL  : pll_reset=1, sys_rst_n=0. After RST_CYCLES cycles, clear the counter -> WAIT_LOCK.
//    WAIT_LOCK  : pll_reset=0. lock_s=1 -> STABLE.
//                 Counter reaching LOCK_TIMEOUT -> retry.
//    STABLE     : lock_s must stay 1 for STABLE_CYCLES cycles -> RUN.
//                 lock_s=0 restarts at WAIT_LOCK; this does not consume a retry
//                 (the timeout counter keeps running from WAIT_LOCK entry).
//    RUN        : sys_rst_n=1, locked=1. Lock loss -> pulse lock_lost, retry.
//    FAIL       : pll_reset=1, sys_rst_n=0, fail=1. Exits only via rst_n or relock_req.
//  - Retry: if retry_cnt==MAX_RETRY -> FAIL; else retry_cnt+=1 and -> RESET_PLL.
//    retry_cnt saturates and never wraps.
//  - relock_req in any state -> RESET_PLL next cycle, with sys_rst_n=0 on that same edge.
//    It does not increment retry_cnt. In FAIL it also clears fail and retry_cnt.
//  - Simultaneous events: rst_n beats relock_req, which beats lock loss,
//    which beats timeout/stable completion.
//  - sys_rst_n asserts on the same edge the FSM leaves RUN; deassertion happens only on RUN entry.
//  - Counter width is $clog2 of the largest of RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES.
//    No wrap; the counter clears on every state change.
// CONFIGURATION
//  PLL_LOCK_GLITCH_FILTER_EN defined:
//    in RUN, lock loss means lock_s low for GLITCH_CYCLES consecutive cycles.
//    Shorter dips are ignored, and locked stays 1 through them.
//  Undefined: a single cycle of lock_s=0 in RUN is a lock loss. GLITCH_CYCLES is unused.
// STRUCTURE
//  pll_rst_pkg: state enum {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL}, and a cnt_width()
//  function for the counter width.
//  Sub-module: sync_2ff (1-bit, reset value 0) for pll_lock. The FSM and counters stay in this file.
// TESTING (defaults; lock driven from bench)
//  1. Release rst_n, raise pll_lock at cycle 100:
//     pll_reset high for cycles 0-15; sys_rst_n rises 100+2+270 cycles later; retry_cnt=0.
//  2. Keep pll_lock=0:
//     a timeout every 16+27000 cycles, retry_cnt steps 1..4.
//     The 5th timeout sets fail=1 with pll_reset=1 held.
//  3. In RUN, drop pll_lock for 1 cycle: without the macro, lock_lost pulses once and sys_rst_n falls.
//     With PLL_LOCK_GLITCH_FILTER_EN there is no reaction. A 4-cycle drop does trigger lock_lost.
//  4. Toggle pll_lock during STABLE at cycle 200:
//     back to WAIT_LOCK, retry_cnt unchanged, sys_rst_n stays 0.
//  5. relock_req in RUN, and again in FAIL:
//     RESET_PLL next cycle, with sys_rst_n=0 on that same edge.
//     In FAIL, fail and retry_cnt also clear.
//  6. Assert rst_n=0 mid-WAIT_LOCK, together with relock_req:
//     all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types for the PLL reset sequencer: FSM state encoding and counter sizing.
package pll_rst_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_e;

    // Width needed to count 0 .. max(a,b,c)-1.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Lock/relock inputs and reset/status outputs of the PLL reset sequencer.
interface pll_reset_sequencer_if #(
    parameter int RCW = 3
);
    logic           pll_lock;
    logic           relock_req;
    logic           pll_reset;
    logic           sys_rst_n;
    logic           locked;
    logic           lock_lost;
    logic           fail;
    logic [RCW-1:0] retry_cnt;

    modport master (
        output pll_lock, relock_req,
        input  pll_reset, sys_rst_n, locked, lock_lost, fail, retry_cnt
    );

    modport slave (
        input  pll_lock, relock_req,
        output pll_reset, sys_rst_n, locked, lock_lost, fail, retry_cnt
    );
endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; clears to 0 on reset.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives rPLL RESET and holds PLL-domain logic in reset until lock is stable; retries, then fails.
// Build macro PLL_LOCK_GLITCH_FILTER_EN: in RUN only GLITCH_CYCLES consecutive lock-low cycles count as loss.
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 27000,
    parameter int STABLE_CYCLES = 270,
    parameter int MAX_RETRY     = 4
`ifdef PLL_LOCK_GLITCH_FILTER_EN
    ,
    parameter int GLITCH_CYCLES = 4
`endif
) (
    input logic                  clkin,
    input logic                  rst_n,
    pll_reset_sequencer_if.slave bus
);
    localparam int CW  = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int RCW = $clog2(MAX_RETRY + 1);

    localparam logic [CW-1:0]  RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]  TMO_LAST  = CW'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that first sees lock_s counts as the first stable cycle.
    localparam logic [CW-1:0]  STB_LAST  = CW'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);
    localparam logic [RCW-1:0] RETRY_MAX = RCW'(MAX_RETRY);

    state_e         state_q;
    state_e         state_d;
    state_e         retry_state_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  tmo_q;
    logic [RCW-1:0] retry_cnt_q;
    logic [RCW-1:0] retry_cnt_d;
    logic [RCW-1:0] retry_inc_d;
    logic           pll_reset_q;
    logic           sys_rst_n_q;
    logic           locked_q;
    logic           lock_lost_q;
    logic           lock_lost_d;
    logic           fail_q;
    logic           lock_s;
    logic           loss_d;
    logic           cnt_clr_d;

    sync_2ff u_lock_sync (
        .clk_i  (clkin),
        .rst_ni (rst_n),
        .d_i    (bus.pll_lock),
        .q_o    (lock_s)
    );

`ifdef PLL_LOCK_GLITCH_FILTER_EN
    localparam int GW = $clog2(GLITCH_CYCLES + 1);
    localparam logic [GW-1:0] GLITCH_LAST = GW'(GLITCH_CYCLES - 1);

    logic [GW-1:0] glitch_q;

    always_ff @(posedge clkin) begin
        if (!rst_n || lock_s || state_q != RUN) begin
            glitch_q <= '0;
        end else if (glitch_q != GLITCH_LAST) begin
            glitch_q <= glitch_q + GW'(1);
        end
    end

    assign loss_d = !lock_s && (glitch_q == GLITCH_LAST);
`else
    assign loss_d = !lock_s;
`endif

    assign retry_state_d = (retry_cnt_q == RETRY_MAX) ? FAIL : RESET_PLL;
    assign retry_inc_d   = (retry_cnt_q == RETRY_MAX) ? retry_cnt_q : retry_cnt_q + RCW'(1);

    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        lock_lost_d = 1'b0;
        if (bus.relock_req) begin
            state_d = RESET_PLL;
            if (state_q == FAIL) retry_cnt_d = '0;
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABLE;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d     = retry_state_d;
                        retry_cnt_d = retry_inc_d;
                    end
                end
                STABLE: begin
                    if (!lock_s)                state_d = WAIT_LOCK;
                    else if (cnt_q == STB_LAST) state_d = RUN;
                end
                RUN: begin
                    if (loss_d) begin
                        state_d     = retry_state_d;
                        retry_cnt_d = retry_inc_d;
                        lock_lost_d = 1'b1;
                    end
                end
                FAIL:    state_d = FAIL;
                default: state_d = RESET_PLL;
            endcase
        end
    end

    // A relock in RESET_PLL keeps the state but must still restart the reset pulse.
    assign cnt_clr_d = bus.relock_req || (state_d != state_q);

    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            tmo_q       <= '0;
            retry_cnt_q <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            retry_cnt_q <= retry_cnt_d;
            lock_lost_q <= lock_lost_d;
            pll_reset_q <= (state_d == RESET_PLL) || (state_d == FAIL);
            sys_rst_n_q <= (state_d == RUN);
            locked_q    <= (state_d == RUN);
            fail_q      <= (state_d == FAIL);

            if (cnt_clr_d) begin
                cnt_q <= '0;
            end else if (state_q == RESET_PLL || state_q == STABLE) begin
                cnt_q <= cnt_q + CW'(1);
            end

            // Timeout spans the whole lock attempt, including detours through STABLE.
            if (state_d == RESET_PLL) begin
                tmo_q <= '0;
            end else if ((state_q == WAIT_LOCK || state_q == STABLE) && tmo_q != TMO_LAST) begin
                tmo_q <= tmo_q + CW'(1);
            end
        end
    end

    assign bus.pll_reset = pll_reset_q;
    assign bus.sys_rst_n = sys_rst_n_q;
    assign bus.locked    = locked_q;
    assign bus.lock_lost = lock_lost_q;
    assign bus.fail      = fail_q;
    assign bus.retry_cnt = retry_cnt_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer; lock timeout shortened so the retry path stays short.
module tb_pll_reset_sequencer;
    localparam int LT = 2000;
    localparam int P  = 16 + LT;

    typedef struct {
        int         cyc;
        logic [7:0] val;
        string      tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    pll_reset_sequencer_if #(.RCW(3)) bus ();

    pll_reset_sequencer #(
        .RST_CYCLES    (16),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (270),
        .MAX_RETRY     (4)
    ) dut (
        .clkin (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] ov;
    assign ov = {bus.pll_reset, bus.sys_rst_n, bus.locked, bus.lock_lost, bus.fail, bus.retry_cnt};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] mk(bit pr, bit sr, bit lk, bit ll, bit fl, int rc);
        logic [2:0] r;
        r = rc[2:0];
        return {pr, sr, lk, ll, fl, r};
    endfunction

    function automatic void expect_at(int c, logic [7:0] v, string t);
        exp_t e;
        e.cyc = c;
        e.val = v;
        e.tag = t;
        sb.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Leaves the bench in cycle 0: first cycle whose rising edge samples rst_n=1.
    task automatic apply_reset();
        rst_n          = 1'b0;
        bus.pll_lock   = 1'b0;
        bus.relock_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic leftover(string name);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expectations never reached", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n          = 1'b0;
        bus.pll_lock   = 1'b1;
        bus.relock_req = 1'b1;
        tick();
        tick();
        tick();
        expect_at(cyc, mk(1, 0, 0, 0, 0, 0), "reset_hold");
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            checks++;
            if (ov !== e.val) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%b exp=%b", e.tag, cyc, ov, e.val);
            end
        end
        apply_reset();
        expect_at(0, mk(1, 0, 0, 0, 0, 0), "reset_release");
        expect_at(3, mk(1, 0, 0, 0, 0, 0), "reset_pll_hold");
        while (cyc <= 5) begin
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (ov !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", e.tag, cyc, ov, e.val);
                end
            end
            tick();
        end
        leftover("test_reset");
    endtask

    task automatic test_lock_up();
        exp_t e;
        apply_reset();
        expect_at(15,  mk(1, 0, 0, 0, 0, 0), "rst_last");
        expect_at(16,  mk(0, 0, 0, 0, 0, 0), "wait_lock_entry");
        expect_at(371, mk(0, 0, 0, 0, 0, 0), "stable_before_run");
        expect_at(372, mk(0, 1, 1, 0, 0, 0), "run_entry");
        while (cyc <= 380) begin
            bus.pll_lock = (cyc >= 100);
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (ov !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", e.tag, cyc, ov, e.val);
                end
            end
            tick();
        end
        leftover("test_lock_up");
    endtask

    task automatic test_retry_fail();
        exp_t e;
        apply_reset();
        for (int k = 1; k <= 4; k++) begin
            expect_at(k * P - 1, mk(0, 0, 0, 0, 0, k - 1), $sformatf("pre_timeout_%0d", k));
            expect_at(k * P,     mk(1, 0, 0, 0, 0, k),     $sformatf("timeout_%0d", k));
        end
        expect_at(5 * P - 1,  mk(0, 0, 0, 0, 0, 4), "pre_fail");
        expect_at(5 * P,      mk(1, 0, 0, 0, 1, 4), "fail_entry");
        expect_at(5 * P + 50, mk(1, 0, 0, 0, 1, 4), "fail_sticky");
        expect_at(5 * P + 61, mk(1, 0, 0, 0, 0, 0), "relock_from_fail");
        expect_at(5 * P + 76, mk(1, 0, 0, 0, 0, 0), "relock_rst_last");
        expect_at(5 * P + 77, mk(0, 0, 0, 0, 0, 0), "relock_wait_lock");
        while (cyc <= 5 * P + 80) begin
            bus.pll_lock   = 1'b0;
            bus.relock_req = (cyc == 5 * P + 60);
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (ov !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", e.tag, cyc, ov, e.val);
                end
            end
            tick();
        end
        bus.relock_req = 1'b0;
        leftover("test_retry_fail");
    endtask

    task automatic test_lock_loss();
        exp_t e;
        apply_reset();
        expect_at(372, mk(0, 1, 1, 0, 0, 0), "loss_run");
`ifdef PLL_LOCK_GLITCH_FILTER_EN
        expect_at(403, mk(0, 1, 1, 0, 0, 0), "dip_ignored");
        expect_at(405, mk(0, 1, 1, 0, 0, 0), "dip_ignored_late");
        expect_at(505, mk(0, 1, 1, 0, 0, 0), "long_dip_pre");
        expect_at(506, mk(1, 0, 0, 1, 0, 1), "long_dip_loss");
        expect_at(507, mk(1, 0, 0, 0, 0, 1), "long_dip_pulse_end");
        while (cyc <= 520) begin
            bus.pll_lock = (cyc >= 100) && (cyc != 400) && !(cyc >= 500 && cyc <= 503);
`else
        expect_at(402, mk(0, 1, 1, 0, 0, 0), "dip_pre");
        expect_at(403, mk(1, 0, 0, 1, 0, 1), "dip_loss");
        expect_at(404, mk(1, 0, 0, 0, 0, 1), "dip_pulse_end");
        expect_at(688, mk(0, 0, 0, 0, 0, 1), "relock_stable");
        expect_at(689, mk(0, 1, 1, 0, 0, 1), "relock_run");
        while (cyc <= 700) begin
            bus.pll_lock = (cyc >= 100) && (cyc != 400);
`endif
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (ov !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", e.tag, cyc, ov, e.val);
                end
            end
            tick();
        end
        leftover("test_lock_loss");
    endtask

    task automatic test_stable_glitch();
        exp_t e;
        apply_reset();
        expect_at(202, mk(0, 0, 0, 0, 0, 0), "stable_drop_seen");
        expect_at(203, mk(0, 0, 0, 0, 0, 0), "back_to_wait");
        expect_at(372, mk(0, 0, 0, 0, 0, 0), "no_early_run");
        expect_at(472, mk(0, 0, 0, 0, 0, 0), "restart_stable_last");
        expect_at(473, mk(0, 1, 1, 0, 0, 0), "restart_run");
        while (cyc <= 480) begin
            bus.pll_lock = (cyc >= 100) && (cyc != 200);
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (ov !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", e.tag, cyc, ov, e.val);
                end
            end
            tick();
        end
        leftover("test_stable_glitch");
    endtask

    task automatic test_relock_run();
        exp_t e;
        apply_reset();
        expect_at(400, mk(0, 1, 1, 0, 0, 0), "relock_pre");
        expect_at(401, mk(1, 0, 0, 0, 0, 0), "relock_reset_pll");
        expect_at(416, mk(1, 0, 0, 0, 0, 0), "relock_rst_last");
        expect_at(417, mk(0, 0, 0, 0, 0, 0), "relock_wait");
        expect_at(686, mk(0, 0, 0, 0, 0, 0), "relock_stable_last");
        expect_at(687, mk(0, 1, 1, 0, 0, 0), "relock_run_again");
        while (cyc <= 690) begin
            bus.pll_lock   = (cyc >= 100);
            bus.relock_req = (cyc == 400);
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (ov !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", e.tag, cyc, ov, e.val);
                end
            end
            tick();
        end
        bus.relock_req = 1'b0;
        leftover("test_relock_run");
    endtask

    task automatic test_reset_priority();
        exp_t e;
        apply_reset();
        expect_at(P,    mk(1, 0, 0, 0, 0, 1), "prio_retry1");
        expect_at(2099, mk(0, 0, 0, 0, 0, 1), "prio_wait");
        expect_at(2101, mk(1, 0, 0, 0, 0, 0), "prio_rst_beats_relock");
        expect_at(2105, mk(1, 0, 0, 0, 0, 0), "prio_after_release");
        while (cyc <= 2110) begin
            bus.pll_lock   = 1'b0;
            rst_n          = (cyc != 2100);
            bus.relock_req = (cyc == 2100);
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (ov !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", e.tag, cyc, ov, e.val);
                end
            end
            tick();
        end
        rst_n          = 1'b1;
        bus.relock_req = 1'b0;
        leftover("test_reset_priority");
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        cyc            = 0;
        rst_n          = 1'b0;
        bus.pll_lock   = 1'b0;
        bus.relock_req = 1'b0;
        test_reset();
        test_lock_up();
        test_retry_fail();
        test_lock_loss();
        test_stable_glitch();
        test_relock_run();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
